vscale_hasti_slave_mux: RTL
===========================

# vscale_hasti_slave_mux

Parametrised HASTI slave-side decoder/multiplexer that sits between the crossbar's shared slave port and N peripheral slaves (UART, simulation UART, timers, GPIO). It decodes the address phase into one-hot slave selects, tracks the outstanding data phase so read data and responses come from the correct slave, and honours wait states. It generates the two-cycle HASTI ERROR response for unmapped addresses and for slaves that stall past a programmable timeout.

## Interface
- N_SLAVES, default 2: number of attached slaves, 1..16.
- SEL_LSB, default 4: lowest address bit of the slave index field.
- SEL_BITS, default 4: width of the slave index field; 2^SEL_BITS must be at least N_SLAVES.
- TIMEOUT, default 255: maximum consecutive wait cycles in a data phase; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- resetn  in  1  asynchronous, active-low reset
- m_sel, m_read, m_write  in  1 each  crossbar slave-port select and transfer type
- m_addr  in  32  address
- m_size  in  3
- m_burst  in  3
- m_prot  in  4
- m_mastlock  in  1
- m_wdata  in  32  write data (data phase)
- m_rdata  out  32  muxed read data
- m_ready  out  1  transfer done / address accepted
- m_resp  out  1  0=OKAY, 1=ERROR
- s_sel, s_read, s_write  out  N_SLAVES each  one-hot per-slave address-phase strobes
- s_addr, s_size, s_burst, s_prot, s_mastlock, s_wdata  out  shared  pass-through of the m_* equivalents
- s_rdata  in  32*N_SLAVES  slave i occupies bits [32*i+31:32*i]
- s_ready  in  N_SLAVES
- s_resp  in  N_SLAVES
- err_count  out  8  saturating count of ERROR responses issued

## Operation
- Index: idx = m_addr[SEL_LSB+SEL_BITS-1:SEL_LSB]. The address is mapped when idx < N_SLAVES.
- Address phase accepted = m_sel & (m_read|m_write) & m_ready.
- s_sel[idx], s_read[idx] and s_write[idx] assert only on an accepted, mapped address phase. All other bits are 0.
- Shared s_* fields are wired straight from the m_* equivalents.

States:
- IDLE: no data phase outstanding. m_ready=1, m_resp=0, m_rdata=0.
  - Accepted mapped transfer: capture dp_idx, go to DATA.
  - Accepted unmapped transfer: go to ERR1.
- DATA: m_ready=s_ready[dp_idx], m_resp=s_resp[dp_idx], m_rdata=s_rdata[dp_idx].
  - On s_ready[dp_idx]=1, the data phase completes. The same cycle may accept the next address phase (pipelined), which goes to DATA (new dp_idx), ERR1, or IDLE.
  - The wait counter wcnt increments each cycle with s_ready[dp_idx]=0.
  - If TIMEOUT≠0 and wcnt reaches TIMEOUT while ready is still low, go to ERR1. Any later ready or data from that slave is ignored.
- ERR1: m_ready=0, m_resp=1. No address phase is accepted. Go to ERR2.
- ERR2: m_ready=1, m_resp=1, m_rdata=0. A new address phase may be accepted, which goes to DATA, ERR1 or IDLE.
- err_count increments once per entry to ERR1 and saturates at 255.
- wcnt clears on every data-phase completion and on every new address-phase acceptance.
- A slave-originated ERROR in DATA is passed through unchanged (the slave drives the two-cycle sequence). Each cycle with s_resp=1 and s_ready=1 also increments err_count.

## Timing
- Reset (asynchronous, resetn=0): state IDLE, dp_idx=0, wcnt=0, err_count=0.
- Output values during reset: m_ready=1, m_resp=0, m_rdata=0, all s_sel/s_read/s_write=0.
- Decode is combinational. A zero-wait slave gives single-cycle data phases, so back-to-back transfers sustain one per cycle.
- The unmapped-address response is exactly 2 data-phase cycles (ERR1, ERR2).
- A timeout response completes TIMEOUT+2 cycles after the address phase.
- Back-to-back transfers to different slaves: the data-phase mux switches on the cycle after acceptance, never earlier.
- resetn asserted mid-transfer abandons the data phase. Slaves are reset by the same resetn.

## Test plan
- Read addr 0x10 (idx 1), slave 1 with zero wait returning 0xCAFEF00D -> s_sel=2'b10 in the address cycle; next cycle m_rdata=0xCAFEF00D, m_ready=1, m_resp=0.
- Back-to-back reads to 0x00 then 0x10, each slave with 2 wait states -> correct data in order, each data phase 3 cycles, no cross-slave data leakage.
- Write to 0x20 with N_SLAVES=2 -> no s_sel asserted; m_ready=0/m_resp=1, then m_ready=1/m_resp=1; err_count=1.
- TIMEOUT=4, slave 0 holds ready low indefinitely -> ERR1 then ERR2, completing at address+6 cycles; a later s_ready pulse is ignored.
- 300 unmapped accesses -> err_count saturates at 255.
- resetn pulsed low during a DATA wait -> outputs immediately show reset values; the next transfer completes normally.

Source files
------------

// File: rtl/vscale_hasti_slave_mux.sv
// rtl/vscale_hasti_slave_mux.sv - HASTI slave-side address decoder and data-phase multiplexer
module vscale_hasti_slave_mux #(
  parameter int N_SLAVES = 2,
  parameter int SEL_LSB  = 4,
  parameter int SEL_BITS = 4,
  parameter int TIMEOUT  = 255
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   m_sel,
  input  logic                   m_read,
  input  logic                   m_write,
  input  logic [31:0]            m_addr,
  input  logic [2:0]             m_size,
  input  logic [2:0]             m_burst,
  input  logic [3:0]             m_prot,
  input  logic                   m_mastlock,
  input  logic [31:0]            m_wdata,
  output logic [31:0]            m_rdata,
  output logic                   m_ready,
  output logic                   m_resp,
  output logic [N_SLAVES-1:0]    s_sel,
  output logic [N_SLAVES-1:0]    s_read,
  output logic [N_SLAVES-1:0]    s_write,
  output logic [31:0]            s_addr,
  output logic [2:0]             s_size,
  output logic [2:0]             s_burst,
  output logic [3:0]             s_prot,
  output logic                   s_mastlock,
  output logic [31:0]            s_wdata,
  input  logic [32*N_SLAVES-1:0] s_rdata,
  input  logic [N_SLAVES-1:0]    s_ready,
  input  logic [N_SLAVES-1:0]    s_resp,
  output logic [7:0]             err_count
);

  localparam int IDX_W  = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam int WCNT_W = $clog2(TIMEOUT + 2);
  // Last wait count before the timeout fires; the limit is reached on the
  // TIMEOUT-th consecutive wait cycle.
  localparam int TLIM   = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
  localparam logic [SEL_BITS:0] N_MAP = N_SLAVES[SEL_BITS:0];
  localparam logic [WCNT_W-1:0] WLIM  = TLIM[WCNT_W-1:0];

  typedef enum logic [1:0] {IDLE, DATA, ERR1, ERR2} state_t;

  state_t              state, state_nx;
  logic [IDX_W-1:0]    dp_idx, dp_idx_nx;
  logic [WCNT_W-1:0]   wcnt, wcnt_nx;
  logic [SEL_BITS-1:0] idx;
  logic                mapped, accept, hit;
  logic                err_entry, slv_err;
  logic                dp_ready, dp_resp;
  logic [31:0]         dp_rdata;
  logic [8:0]          err_sum;

  assign idx    = m_addr[SEL_LSB +: SEL_BITS];
  assign mapped = {1'b0, idx} < N_MAP;
  // Gating with resetn keeps every strobe low while reset is held.
  assign accept = resetn & m_sel & (m_read | m_write) & m_ready;
  assign hit    = accept & mapped;

  assign s_addr     = m_addr;
  assign s_size     = m_size;
  assign s_burst    = m_burst;
  assign s_prot     = m_prot;
  assign s_mastlock = m_mastlock;
  assign s_wdata    = m_wdata;

  // Select ready/resp/rdata of the slave owning the current data phase.
  always_comb begin
    dp_ready = 1'b0;
    dp_resp  = 1'b0;
    dp_rdata = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (dp_idx == IDX_W'(i)) begin
        dp_ready = s_ready[i];
        dp_resp  = s_resp[i];
        dp_rdata = s_rdata[32*i +: 32];
      end
    end
  end

  // One-hot address-phase strobes for an accepted, mapped transfer.
  always_comb begin
    s_sel   = '0;
    s_read  = '0;
    s_write = '0;
    for (int i = 0; i < N_SLAVES; i++) begin
      if (hit && idx == SEL_BITS'(i)) begin
        s_sel[i]   = 1'b1;
        s_read[i]  = m_read;
        s_write[i] = m_write;
      end
    end
  end

  // Master-side response outputs by state.
  always_comb begin
    m_ready = 1'b1;
    m_resp  = 1'b0;
    m_rdata = '0;
    case (state)
      DATA: begin
        m_ready = dp_ready;
        m_resp  = dp_resp;
        m_rdata = dp_rdata;
      end
      ERR1: begin
        m_ready = 1'b0;
        m_resp  = 1'b1;
      end
      ERR2: m_resp = 1'b1;
      default: ;
    endcase
  end

  // Next state, data-phase owner, wait counter and error events.
  always_comb begin
    state_nx  = state;
    dp_idx_nx = dp_idx;
    wcnt_nx   = '0;
    case (state)
      DATA: begin
        if (dp_ready) begin
          state_nx = IDLE;
        end else if (TIMEOUT != 0 && wcnt == WLIM) begin
          state_nx = ERR1;
        end else if (wcnt != '1) begin
          wcnt_nx = wcnt + 1'b1;
        end else begin
          wcnt_nx = wcnt;
        end
      end
      ERR1:    state_nx = ERR2;
      ERR2:    state_nx = IDLE;
      default: ;
    endcase
    if (accept) begin
      wcnt_nx = '0;
      if (mapped) begin
        state_nx  = DATA;
        dp_idx_nx = idx[IDX_W-1:0];
      end else begin
        state_nx = ERR1;
      end
    end
    err_entry = (state_nx == ERR1);
    slv_err   = (state == DATA) & dp_ready & dp_resp;
    err_sum   = {1'b0, err_count} + {8'b0, err_entry} + {8'b0, slv_err};
  end

  // State registers with saturating error counter.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      dp_idx    <= '0;
      wcnt      <= '0;
      err_count <= '0;
    end else begin
      state     <= state_nx;
      dp_idx    <= dp_idx_nx;
      wcnt      <= wcnt_nx;
      err_count <= err_sum[8] ? 8'hFF : err_sum[7:0];
    end
  end

endmodule
